sum_accumulator: RTL



---
 rtl/sum_accumulator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator
// Collects NUM_SAMPLES adder results ({cout_in, sum_in}) over a valid/ready
// handshake and sums them into an ACC_W-bit register. When the batch is complete
// the block presents the total with a sticky overflow flag until the sink takes it.
//
// Parameters
//   DATA_W      adder Sum width; each sample is DATA_W+1 bits including carry
//   ACC_W       accumulator width, must be >= DATA_W+1
//   NUM_SAMPLES samples per batch, must be >= 1
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle pulse, begins a batch (honoured only when idle)
//   sum_in     adder Sum
//   cout_in    adder Cout
//   in_valid   sum_in/cout_in valid
//   in_ready   block accepts a sample this cycle
//   acc_out    accumulated total, registered
//   out_valid  acc_out holds a completed batch
//   out_ready  sink consumes the result
//   overflow   sticky; accumulator wrapped during the current or last batch
//   busy       batch in progress or result waiting
module sum_accumulator #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ACC_W       = 12,
  parameter int unsigned NUM_SAMPLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] sum_in,
  input  logic              cout_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
);

  // One extra bit so the count can reach NUM_SAMPLES without wrapping.
  localparam int unsigned       CNT_W    = $clog2(NUM_SAMPLES) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           r_state, w_state_d;
  logic [ACC_W-1:0] r_acc, w_acc_d;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic             r_overflow, w_overflow_d;

  logic             w_xfer;
  logic [ACC_W:0]   w_sum;

  // in_ready depends on state only, so a transfer never loops back through in_valid.
  assign w_xfer = in_valid && (r_state == StAccum);

  // Top bit of the widened sum is the wrap indication for this transfer.
  assign w_sum = {1'b0, r_acc} + (ACC_W+1)'({cout_in, sum_in});

  always_comb begin
    w_state_d    = r_state;
    w_acc_d      = r_acc;
    w_count_d    = r_count;
    w_overflow_d = r_overflow;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_acc_d      = '0;
          w_count_d    = '0;
          w_overflow_d = 1'b0;
          w_state_d    = StAccum;
        end
      end
      StAccum: begin
        // Data inputs are only looked at on a transfer, so X outside one is harmless.
        if (w_xfer) begin
          w_acc_d      = w_sum[ACC_W-1:0];
          w_overflow_d = r_overflow | w_sum[ACC_W];
          w_count_d    = r_count + 1'b1;
          if (r_count == LAST_CNT) begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        // start is deliberately ignored here, even alongside out_ready.
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_acc      <= w_acc_d;
      r_count    <= w_count_d;
      r_overflow <= w_overflow_d;
    end
  end

  assign in_ready  = (r_state == StAccum);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign acc_out   = r_acc;
  assign overflow  = r_overflow;

endmodule
